// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - registered round-robin arbiter with lock-based burst chaining
module rr_lock_arbiter #(
    parameter int N_REQ     = 4,
    parameter int W_IDX     = 2,
    parameter int MAX_BURST = 4,
    parameter int W_BURST   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [W_IDX-1:0] gnt_idx,
    output logic             busy
);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t             state;
    logic [N_REQ-1:0]   mask;
    logic [N_REQ-1:0]   masked;
    logic [N_REQ-1:0]   src;
    logic [N_REQ-1:0]   next_mask;
    logic [W_IDX-1:0]   pick_idx;
    logic               pick_valid;
    logic               keep;
    logic [W_BURST-1:0] burst_cnt;

    // Requesters above the last winner get priority; fall back to the whole set to wrap.
    always_comb begin
        masked     = req & mask;
        src        = (masked != '0) ? masked : req;
        pick_valid = (req != '0);
        pick_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (src[i]) pick_idx = W_IDX'(i);
        end
        next_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            next_mask[i] = (i > int'(pick_idx));
        end
    end

    assign keep = lock[gnt_idx] && req[gnt_idx] &&
                  ((MAX_BURST == 0) || (burst_cnt < W_BURST'(MAX_BURST - 1)));

    assign busy = |gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            burst_cnt <= '0;
            mask      <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= GRANTED;
                        gnt       <= N_REQ'(1) << pick_idx;
                        gnt_idx   <= pick_idx;
                        burst_cnt <= '0;
                        mask      <= next_mask;
                    end
                end
                GRANTED: begin
                    if (done) begin
                        if (keep) begin
                            // Saturation only matters in unlimited mode; a finite limit stops earlier.
                            if (burst_cnt != '1) burst_cnt <= burst_cnt + W_BURST'(1);
                        end else if (pick_valid) begin
                            gnt       <= N_REQ'(1) << pick_idx;
                            gnt_idx   <= pick_idx;
                            burst_cnt <= '0;
                            mask      <= next_mask;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_index:  assert property (@(posedge clk) disable iff (rst) busy |-> gnt[gnt_idx]);
    a_stable: assert property (@(posedge clk) disable iff (rst)
                  $changed(gnt) |-> ($past(rst) || $past(done) || $past(state == IDLE)));

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb/tb_rr_lock_arbiter.sv - self-checking bench for rr_lock_arbiter
module tb_rr_lock_arbiter;
    localparam int N    = 4;
    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] lock = '0;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    rr_lock_arbiter #(.N_REQ(4), .W_IDX(2), .MAX_BURST(MAXB), .W_BURST(3)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: holder of the resource (-1 when idle), last winner for rotation.
    int m_hold  = -1;
    int m_idx   = 0;
    int m_last  = N - 1;
    int m_burst = 0;
    bit model_valid = 1'b0;

    function automatic int pick(input logic [3:0] r, input int last);
        for (int off = 1; off <= N; off++) begin
            if (r[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt(input int h);
        logic [3:0] g;
        g = '0;
        if (h >= 0) g[h] = 1'b1;
        return g;
    endfunction

    always @(posedge clk) begin
        model_valid <= 1'b1;
        if (rst) begin
            m_hold  <= -1;
            m_idx   <= 0;
            m_last  <= N - 1;
            m_burst <= 0;
        end else if (m_hold < 0 || done) begin
            if (m_hold >= 0 && lock[m_hold] && req[m_hold] && (MAXB == 0 || m_burst < MAXB - 1)) begin
                m_burst <= m_burst + 1;
            end else if (pick(req, m_last) >= 0) begin
                m_hold  <= pick(req, m_last);
                m_idx   <= pick(req, m_last);
                m_last  <= pick(req, m_last);
                m_burst <= 0;
            end else begin
                m_hold <= -1;
            end
        end
    end

    int wait_cnt [4] = '{0, 0, 0, 0};
    int max_wait = 0;

    always @(negedge clk) begin
        if (model_valid) begin
            n_checks++;
            if (gnt !== exp_gnt(m_hold) || gnt_idx !== 2'(m_idx) || busy !== (m_hold >= 0)) begin
                n_fail++;
                $display("FAIL model t=%0t gnt=%b idx=%0d busy=%b expected gnt=%b idx=%0d busy=%b",
                         $time, gnt, gnt_idx, busy, exp_gnt(m_hold), m_idx, (m_hold >= 0));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rst || gnt[i] || !req[i]) wait_cnt[i] = 0;
            else if (done && gnt != '0) wait_cnt[i] = wait_cnt[i] + 1;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
    end

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic d, input logic rs);
        req = r; lock = l; done = d; rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] g, input int idx, input logic b);
        n_checks++;
        if (gnt !== g || gnt_idx !== 2'(idx) || busy !== b) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                     name, gnt, gnt_idx, busy, g, idx, b);
        end
    endtask

    logic [3:0] rr;
    logic [3:0] rl;

    initial begin
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("reset", 4'b0000, 0, 1'b0);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        check("done_idle", 4'b0000, 0, 1'b0);

        step(4'b1010, 4'b0000, 1'b0, 1'b0);
        check("first_grant", 4'b0010, 1, 1'b1);
        step(4'b1010, 4'b0000, 1'b1, 1'b0);
        check("rotate_up", 4'b1000, 3, 1'b1);
        step(4'b1010, 4'b0000, 1'b1, 1'b0);
        check("wrap", 4'b0010, 1, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        check("release_idle", 4'b0000, 1, 1'b0);

        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step(4'b1111, 4'b0000, 1'b1, 1'b0);
            check("rr_order", 4'(1 << (k % 4)), k % 4, 1'b1);
        end

        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0011, 4'b0001, 1'b0, 1'b0);
        check("lock_start", 4'b0001, 0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step(4'b0011, 4'b0001, 1'b1, 1'b0);
            check("lock_hold", 4'b0001, 0, 1'b1);
        end
        step(4'b0011, 4'b0001, 1'b1, 1'b0);
        check("burst_limit", 4'b0010, 1, 1'b1);

        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        check("grant2", 4'b0100, 2, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("hold_no_done", 4'b0100, 2, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        check("drop_idle", 4'b0000, 2, 1'b0);

        step(4'b1000, 4'b0000, 1'b0, 1'b0);
        check("grant3", 4'b1000, 3, 1'b1);
        step(4'b1000, 4'b0000, 1'b1, 1'b1);
        check("rst_mid", 4'b0000, 0, 1'b0);
        step(4'b1000, 4'b0000, 1'b0, 1'b0);
        check("after_rst", 4'b1000, 3, 1'b1);

        rr = 4'b1111;
        rl = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) rr = 4'($urandom);
            if ($urandom_range(0, 3) == 0) rl = 4'($urandom);
            step(rr, rl, ($urandom_range(0, 2) == 0), 1'b0);
        end
        n_checks++;
        if (max_wait > N * MAXB) begin
            n_fail++;
            $display("FAIL fairness: max wait %0d transfers, limit %0d", max_wait, N * MAXB);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
